// File: rtl/ser_pkg.sv
// Shared types for the serialization table walker: table entry layout and walker states.
package ser_pkg;

  localparam int ENTRY_BYTES = 16;

  typedef struct packed {
    logic [63:0] desc;
    logic [63:0] sub_addr;
  } table_entry_t;

  typedef enum logic [2:0] {
    IDLE, FETCH_LO, FETCH_HI, ISSUE, WAIT_SA, POP, DONE, ERR
  } walk_state_t;

endpackage

// File: rtl/ser_walk_stack.sv
// LIFO of return pointers for nested sub-tables.
// Latency: push/pop take effect on the next edge; top_dat is combinational.
// Backpressure: push ignored when full, pop ignored when empty; clr wins over both.
module ser_walk_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int LW    = $clog2(DEPTH + 1),
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_dat,
  output logic [W-1:0] top_dat,
  output logic         empty,
  output logic         full
);

  logic [W-1:0]  mem [DEPTH];
  logic [LW-1:0] lvl;
  logic [LW-1:0] top_idx;

  assign empty   = (lvl == '0);
  assign full    = (lvl == LW'(DEPTH));
  assign top_idx = lvl - LW'(1);
  assign top_dat = mem[top_idx[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                lvl <= '0;
    else if (clr)              lvl <= '0;
    else if (push && !full)    lvl <= lvl + LW'(1);
    else if (pop && !empty)    lvl <= lvl - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (!clr && push && !full) mem[lvl[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/ser_table_walker.sv
// Walks a nested descriptor table in DRAM and feeds each 16-byte entry to ser_aggregate.
// Latency: >= 6 cycles per entry (2 per fetch half, 1 issue, 1 handshake), +1 per stack pop.
// Backpressure: stalls in ISSUE on sa_ready low and in WAIT_SA until sa_done; SER_WALK_STATS_EN adds stats ports.
module ser_table_walker
  import ser_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int MAX_ENTRIES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [63:0]      table_addr,
  input  logic [63:0]      obj_addr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             sa_en,
  output logic             sa_entry_valid,
  output logic [63:0]      sa_addr,
  output table_entry_t     sa_entry,
  input  logic             sa_done,
  input  logic             sa_ready,
  output logic [7:0]       dram_en,
  output logic             dram_rdwr,
  output logic [7:0][63:0] dram_addr,
  input  logic [7:0][7:0]  dram_data_in,
  input  logic [7:0]       dram_valid
`ifdef SER_WALK_STATS_EN
  ,
  output logic [31:0]      entries_walked,
  output logic [2:0]       max_depth
`endif
);

`ifdef SER_WALK_STATS_EN
  localparam int CW = 32;
`else
  localparam int CW = $clog2(MAX_ENTRIES + 2);
`endif

  walk_state_t    state, nxt_state;
  logic [63:0]    cur_ptr, obj_q, fetch_base, stk_top;
  table_entry_t   entry_q;
  logic [7:0][7:0] lane_dat, cap_bytes;
  logic [7:0]     lane_got, got_nxt;
  logic           fetch_req, fetch_st, fetch_cap;
  logic [CW-1:0]  cnt;
  logic           is_term, is_nested;
  logic           stk_push, stk_pop, stk_clr, stk_empty, stk_full;

  // The first cycle of each fetch half is idle so a late lane from the previous request cannot alias.
  assign fetch_st   = (state == FETCH_LO) || (state == FETCH_HI);
  assign fetch_base = cur_ptr + ((state == FETCH_HI) ? 64'd8 : 64'd0);
  assign got_nxt    = lane_got | dram_valid;
  assign fetch_cap  = fetch_st && fetch_req && (got_nxt == 8'hFF);
  always_comb begin
    for (int i = 0; i < 8; i++)
      cap_bytes[i] = dram_valid[i] ? dram_data_in[i] : lane_dat[i];
  end

  assign is_term   = (entry_q.desc == '0);
  assign is_nested = !is_term && (entry_q.sub_addr != '0);
  assign stk_clr   = (state == IDLE) && start;
  assign stk_push  = (state == WAIT_SA) && sa_done && (nxt_state == FETCH_LO) && is_nested;
  assign stk_pop   = (state == POP) && !stk_empty;

  ser_walk_stack #(.DEPTH(STACK_DEPTH), .W(64)) u_stack (
    .clk      (clk),
    .reset    (reset),
    .clr      (stk_clr),
    .push     (stk_push),
    .pop      (stk_pop),
    .push_dat (cur_ptr + 64'(ENTRY_BYTES)),
    .top_dat  (stk_top),
    .empty    (stk_empty),
    .full     (stk_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:     if (start) nxt_state = FETCH_LO;
      FETCH_LO: if (fetch_cap) nxt_state = FETCH_HI;
      FETCH_HI: if (fetch_cap) nxt_state = ISSUE;
      ISSUE:    if (sa_ready) nxt_state = WAIT_SA;
      WAIT_SA: begin
        if (sa_done) begin
          if (cnt == CW'(MAX_ENTRIES + 1))   nxt_state = ERR;
          else if (is_term)                  nxt_state = POP;
          else if (is_nested && stk_full)    nxt_state = ERR;
          else                               nxt_state = FETCH_LO;
        end
      end
      POP:      nxt_state = stk_empty ? DONE : FETCH_LO;
      DONE:     nxt_state = IDLE;
      ERR:      nxt_state = IDLE;
      default:  nxt_state = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state != IDLE) && (state != DONE) && (state != ERR);
    done           = (state == DONE) || (state == ERR);
    sa_en          = (state == WAIT_SA);
    sa_entry_valid = sa_en;
    dram_en        = (fetch_st && fetch_req) ? 8'hFF : 8'h00;
    for (int i = 0; i < 8; i++)
      dram_addr[i] = fetch_st ? fetch_base + 64'(i) : 64'd0;
  end

  assign sa_addr   = obj_q;
  assign sa_entry  = entry_q;
  assign dram_rdwr = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_ptr   <= '0;
      obj_q     <= '0;
      entry_q   <= '0;
      lane_dat  <= '0;
      lane_got  <= '0;
      fetch_req <= 1'b0;
      cnt       <= '0;
      err       <= 1'b0;
    end else begin
      if (stk_clr) begin
        cur_ptr <= table_addr;
        obj_q   <= obj_addr;
        cnt     <= '0;
        err     <= 1'b0;
      end
      if (fetch_st) begin
        if (!fetch_req) begin
          fetch_req <= 1'b1;
        end else if (fetch_cap) begin
          fetch_req <= 1'b0;
          lane_got  <= '0;
          if (state == FETCH_LO) entry_q.sub_addr <= cap_bytes;
          else                   entry_q.desc     <= cap_bytes;
        end else begin
          lane_got <= got_nxt;
          lane_dat <= cap_bytes;
        end
      end
      if ((state == ISSUE) && sa_ready) cnt <= cnt + CW'(1);
      if ((state == WAIT_SA) && sa_done) begin
        if (nxt_state == ERR)           err     <= 1'b1;
        else if (nxt_state == FETCH_LO) cur_ptr <= is_nested ? entry_q.sub_addr
                                                             : cur_ptr + 64'(ENTRY_BYTES);
      end
      if (stk_pop) cur_ptr <= stk_top;
    end
  end

`ifdef SER_WALK_STATS_EN
  logic [2:0] depth_q, max_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth_q <= '0;
      max_q   <= '0;
    end else if (stk_clr) begin
      depth_q <= '0;
      max_q   <= '0;
    end else if (stk_push) begin
      depth_q <= depth_q + 3'd1;
      if (depth_q + 3'd1 > max_q) max_q <= depth_q + 3'd1;
    end else if (stk_pop) begin
      depth_q <= depth_q - 3'd1;
    end
  end

  assign entries_walked = cnt;
  assign max_depth      = max_q;
`endif

endmodule

// File: tb/tb_ser_table_walker.sv
// Directed bench for ser_table_walker: DRAM byte-lane model with per-lane latency and an sa_done stub.
module tb_ser_table_walker;
  import ser_pkg::*;

  localparam logic [63:0] D1 = 64'h0000001340080101;
  localparam logic [63:0] D2 = 64'h0000000940080008;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b0, start = 1'b0;
  logic [63:0]      table_addr = '0, obj_addr = '0;
  logic             busy, done, err, sa_en, sa_entry_valid, dram_rdwr;
  logic [63:0]      sa_addr;
  table_entry_t     sa_entry;
  logic             sa_done = 1'b0, sa_ready = 1'b1;
  logic [7:0]       dram_en;
  logic [7:0][63:0] dram_addr;
  logic [7:0][7:0]  dram_data_in = '0;
  logic [7:0]       dram_valid = '0;
`ifdef SER_WALK_STATS_EN
  logic [31:0]      entries_walked;
  logic [2:0]       max_depth;
`endif

  int n_run = 0, n_fail = 0;
  logic [7:0] mem [logic [63:0]];
  int lat [8];
  int fcnt = 0, done_cnt = 0;
  bit sa_auto = 1'b1, sa_en_d = 1'b0;
  table_entry_t iss_q[$], exp_q[$];
  logic [63:0]  fetch_q[$];

  ser_table_walker dut (
    .clk(clk), .reset(reset), .start(start), .table_addr(table_addr), .obj_addr(obj_addr),
    .busy(busy), .done(done), .err(err), .sa_en(sa_en), .sa_entry_valid(sa_entry_valid),
    .sa_addr(sa_addr), .sa_entry(sa_entry), .sa_done(sa_done), .sa_ready(sa_ready),
    .dram_en(dram_en), .dram_rdwr(dram_rdwr), .dram_addr(dram_addr),
    .dram_data_in(dram_data_in), .dram_valid(dram_valid)
`ifdef SER_WALK_STATS_EN
    , .entries_walked(entries_walked), .max_depth(max_depth)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic table_entry_t mk(input logic [63:0] d, input logic [63:0] s);
    table_entry_t e;
    e.desc = d;
    e.sub_addr = s;
    return e;
  endfunction

  task automatic put_entry(input logic [63:0] a, input logic [63:0] d, input logic [63:0] s);
    for (int i = 0; i < 8; i++) begin
      mem[a + 64'(i)]     = s[8*i +: 8];
      mem[a + 64'(8 + i)] = d[8*i +: 8];
    end
    exp_q.push_back(mk(d, s));
  endtask

  // Lane i answers exactly once, lat[i] cycles into the request; other cycles carry junk.
  always @(negedge clk) begin
    if (dram_en == 8'hFF) begin
      if (fcnt == 0) fetch_q.push_back(dram_addr[0]);
      fcnt++;
    end else begin
      fcnt = 0;
    end
    for (int i = 0; i < 8; i++) begin
      if (dram_en[i] && fcnt == lat[i]) begin
        dram_valid[i]   = 1'b1;
        dram_data_in[i] = rd(dram_addr[i]);
      end else begin
        dram_valid[i]   = 1'b0;
        dram_data_in[i] = 8'hEE;
      end
    end
  end

  always @(negedge clk) begin
    if (sa_en && !sa_en_d) iss_q.push_back(sa_entry);
    sa_en_d = sa_en;
    sa_done = sa_en && sa_auto;
    if (done) done_cnt++;
  end

  task automatic new_test();
    repeat (3) @(negedge clk);
    mem.delete();
    exp_q.delete();
    iss_q.delete();
    fetch_q.delete();
  endtask

  task automatic kick(input logic [63:0] t, input logic [63:0] o);
    table_addr = t;
    obj_addr   = o;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // cyc counts cycles from the start pulse to the cycle done is high.
  task automatic wait_done(input string tag, input int maxc, output int cyc, output logic e);
    cyc = 0;
    e   = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (done) begin
        cyc = c + 2;
        e   = err;
        break;
      end
    end
    chk({tag, "_done_seen"}, 128'(cyc != 0), 128'(1));
  endtask

  task automatic chk_issues(input string tag);
    chk({tag, "_n_issued"}, 128'(iss_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < iss_q.size(); i++)
      chk($sformatf("%s_entry%0d", tag, i), iss_q[i], exp_q[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, d0, found;
    logic e;
    for (int i = 0; i < 8; i++) lat[i] = 1;

    repeat (3) @(negedge clk);
    chk("rst_ctrl", {busy, done, err, sa_en, sa_entry_valid, dram_rdwr}, '0);
    chk("rst_dram_en", dram_en, 0);
    chk("rst_dram_addr7", dram_addr[7], 0);
    chk("rst_sa_entry", sa_entry, 0);
    chk("rst_sa_addr", sa_addr, 0);
    reset = 1'b1;

    // Flat table: two entries then a terminator, minimum latency 3*6+2.
    new_test();
    put_entry(64'h10, D1, 64'h0);
    put_entry(64'h20, D2, 64'h0);
    put_entry(64'h30, 64'h0, 64'h0);
    d0 = done_cnt;
    kick(64'h10, 64'hCAFE_0000);
    wait_done("flat", 100, cyc, e);
    chk("flat_latency", 128'(cyc), 128'(20));
    chk("flat_err", e, 0);
    repeat (3) @(negedge clk);
    chk("flat_one_done", 128'(done_cnt - d0), 128'(1));
    chk_issues("flat");

    // One level of nesting; the pop must resume at 0x20.
    new_test();
    put_entry(64'h10, D1, 64'h100);
    put_entry(64'h100, D2, 64'h0);
    put_entry(64'h110, 64'h0, 64'h0);
    put_entry(64'h20, 64'h0, 64'h0);
    kick(64'h10, 64'h5000);
    wait_done("nest", 100, cyc, e);
    chk("nest_latency", 128'(cyc), 128'(27));
    chk("nest_err", e, 0);
    chk_issues("nest");
    chk("nest_n_fetch", 128'(fetch_q.size()), 128'(8));
    if (fetch_q.size() > 6) chk("nest_pop_ptr", fetch_q[6], 64'h20);

    // Staggered lanes: lane i answers after 1+(i%4) cycles, so each fetch half is 5 cycles.
    new_test();
    for (int i = 0; i < 8; i++) lat[i] = 1 + (i % 4);
    put_entry(64'h40, 64'hA1B2C3D4E5F60718, 64'h0);
    put_entry(64'h50, 64'h0, 64'hF0E1D2C3B4A59687);
    kick(64'h40, 64'h7000);
    wait_done("stag", 200, cyc, e);
    chk("stag_latency", 128'(cyc), 128'(26));
    chk_issues("stag");
    for (int i = 0; i < 8; i++) lat[i] = 1;

    // Five nested pointers against a 4-deep stack.
    new_test();
    put_entry(64'h10, D1, 64'h100);
    put_entry(64'h100, D1, 64'h200);
    put_entry(64'h200, D1, 64'h300);
    put_entry(64'h300, D1, 64'h400);
    put_entry(64'h400, D1, 64'h500);
    d0 = done_cnt;
    kick(64'h10, 64'h9000);
    wait_done("deep", 100, cyc, e);
    chk("deep_latency", 128'(cyc), 128'(31));
    chk("deep_err_at_done", e, 1);
    repeat (5) @(negedge clk);
    chk("deep_one_done", 128'(done_cnt - d0), 128'(1));
    chk("deep_busy_after", busy, 0);
    chk("deep_err_sticky", err, 1);
    chk_issues("deep");
`ifdef SER_WALK_STATS_EN
    chk("deep_max_depth", max_depth, 4);
`endif

    // Reset while parked in WAIT_SA, then a clean rerun.
    new_test();
    put_entry(64'h10, D1, 64'h0);
    put_entry(64'h20, D2, 64'h0);
    put_entry(64'h30, 64'h0, 64'h0);
    sa_auto = 1'b0;
    kick(64'h10, 64'h1234_0000);
    found = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (sa_en) begin
        found = 1;
        break;
      end
    end
    chk("rst_reach_wait_sa", 128'(found), 128'(1));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_ctrl", {busy, done, err, sa_en, sa_entry_valid}, '0);
    chk("midrst_dram_en", dram_en, 0);
    chk("midrst_sa_entry", sa_entry, 0);
    chk("midrst_sa_addr", sa_addr, 0);
    @(negedge clk);
    reset   = 1'b1;
    sa_auto = 1'b1;
    repeat (2) @(negedge clk);
    iss_q.delete();
    kick(64'h10, 64'h1234_0000);
    wait_done("rerun", 100, cyc, e);
    chk("rerun_latency", 128'(cyc), 128'(20));
    chk("rerun_err", e, 0);
    chk_issues("rerun");

    // sa_ready low for >10 cycles in ISSUE; a start pulse meanwhile is ignored.
    new_test();
    put_entry(64'h10, D1, 64'h0);
    put_entry(64'h20, D2, 64'h0);
    put_entry(64'h30, 64'h0, 64'h0);
    sa_ready = 1'b0;
    kick(64'h10, 64'hABCD_0000);
    repeat (6) @(negedge clk);
    kick(64'h500, 64'hDEAD_0000);
    repeat (8) @(negedge clk);
    chk("rdy_sa_en_low", sa_en, 0);
    chk("rdy_none_issued", 128'(iss_q.size()), 128'(0));
    chk("rdy_busy", busy, 1);
    chk("rdy_sa_addr", sa_addr, 64'hABCD_0000);
    sa_ready = 1'b1;
    wait_done("rdy", 100, cyc, e);
    chk("rdy_err", e, 0);
    chk_issues("rdy");
`ifdef SER_WALK_STATS_EN
    chk("rdy_entries_walked", entries_walked, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
